// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: pin synchronizers, clock deglitch filter,
// 11-bit frame deserializer, one-entry valid/ready holding register and
// single-cycle protocol error pulses.
module ps2_rx_frame #(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 5000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   input  logic       rx_enable,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       busy,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overrun,
   output logic       timeout_err
);

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
   logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
   logic          ps2_clk_f_q, ps2_clk_f_d;
   logic          clk_f_prev_q, clk_f_prev_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   state_t        state_q, state_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          par_q, par_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_valid_q, rx_valid_d;
   logic          parity_err_q, parity_err_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;
   logic          timeout_err_q, timeout_err_d;
   logic          fall;
   logic          pop;

   // Two-flop synchronizers on both raw pins
   always_comb begin
      clk_s1_d = ps2_clk_in;
      clk_s2_d = clk_s1_q;
      dat_s1_d = ps2_data_in;
      dat_s2_d = dat_s1_q;
   end

   // Clock filter: adopt the synchronized level only after FILTER_LEN differing cycles
   always_comb begin
      ps2_clk_f_d  = ps2_clk_f_q;
      filt_cnt_d   = '0;
      clk_f_prev_d = ps2_clk_f_q;
      if (clk_s2_q != ps2_clk_f_q) begin
         if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            ps2_clk_f_d = clk_s2_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   assign fall = clk_f_prev_q & ~ps2_clk_f_q;
   assign pop  = rx_valid_q & rx_ready;

   // Frame FSM, timeout, holding register and error pulse generation
   always_comb begin
      state_d       = state_q;
      bitcnt_d      = bitcnt_q;
      shreg_d       = shreg_q;
      par_d         = par_q;
      to_cnt_d      = '0;
      rx_data_d     = rx_data_q;
      rx_valid_d    = rx_valid_q & ~pop;
      parity_err_d  = 1'b0;
      frame_err_d   = 1'b0;
      overrun_d     = 1'b0;
      timeout_err_d = 1'b0;
      if (!rx_enable) begin
         state_d  = IDLE;
         bitcnt_d = '0;
      end else if (fall) begin
         unique case (state_q)
            IDLE: begin
               if (!dat_s2_q) begin
                  state_d  = DATA;
                  bitcnt_d = '0;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            DATA: begin
               shreg_d  = {dat_s2_q, shreg_q[7:1]};
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q == 3'd7) begin
                  state_d = PARITY;
               end
            end
            PARITY: begin
               par_d   = dat_s2_q;
               state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (!dat_s2_q) begin
                  frame_err_d = 1'b1;
               end else if (!(^{shreg_q, par_q})) begin
                  parity_err_d = 1'b1;
               end else if (rx_valid_q && !pop) begin
                  overrun_d = 1'b1;
               end else begin
                  rx_data_d  = shreg_q;
                  rx_valid_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE) begin
         if (to_cnt_q == TW'(TIMEOUT_CYCLES)) begin
            timeout_err_d = 1'b1;
            state_d       = IDLE;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end
   end

   // State registers, all asynchronously reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_s1_q      <= 1'b1;
         clk_s2_q      <= 1'b1;
         dat_s1_q      <= 1'b1;
         dat_s2_q      <= 1'b1;
         ps2_clk_f_q   <= 1'b1;
         clk_f_prev_q  <= 1'b1;
         filt_cnt_q    <= '0;
         state_q       <= IDLE;
         bitcnt_q      <= '0;
         shreg_q       <= '0;
         par_q         <= 1'b0;
         to_cnt_q      <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         parity_err_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         overrun_q     <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         clk_s1_q      <= clk_s1_d;
         clk_s2_q      <= clk_s2_d;
         dat_s1_q      <= dat_s1_d;
         dat_s2_q      <= dat_s2_d;
         ps2_clk_f_q   <= ps2_clk_f_d;
         clk_f_prev_q  <= clk_f_prev_d;
         filt_cnt_q    <= filt_cnt_d;
         state_q       <= state_d;
         bitcnt_q      <= bitcnt_d;
         shreg_q       <= shreg_d;
         par_q         <= par_d;
         to_cnt_q      <= to_cnt_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         parity_err_q  <= parity_err_d;
         frame_err_q   <= frame_err_d;
         overrun_q     <= overrun_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign busy        = (state_q != IDLE);
   assign parity_err  = parity_err_q;
   assign frame_err   = frame_err_q;
   assign overrun     = overrun_q;
   assign timeout_err = timeout_err_q;

endmodule
